// File: rtl/datapath_pkg.sv
// Shared datapath definitions for the single-issue core.
// Provides the default register/word widths, well-known register numbers
// and the address/word typedefs used by the register bank.
package datapath_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_SP   = 5'd29;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/reg_bank_rport.sv
// Combinational read port of the register bank.
// Ports:
//   ra      read address
//   stored  current contents of regs[ra], selected in the parent
//   we, rst write enable and reset of the parent bank (bypass qualifiers)
//   wa, wd  write address/data of the parent bank
//   rd      read data
module reg_bank_rport
    import datapath_pkg::*;
#(
    parameter int DATA_W = datapath_pkg::DATA_W,
    parameter int ADDR_W = datapath_pkg::ADDR_W,
    parameter bit BYPASS = 1'b1
) (
    input  logic [ADDR_W-1:0] ra,
    input  logic [DATA_W-1:0] stored,
    input  logic              we,
    input  logic              rst,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd
);

    logic hit;

    // A pending write is forwarded only if it will actually land at the edge;
    // a reset in the same cycle discards it, so no forwarding then.
    assign hit = BYPASS && we && !rst && (wa == ra);

    always_comb begin
        rd = stored;
        if (ra == '0)
            rd = '0;
        else if (hit)
            rd = wd;
    end

endmodule

// File: rtl/reg_bank.sv
// 32-entry general-purpose register bank, 2 combinational read ports,
// 1 synchronous write port. Register 0 always reads zero.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous reset, active-high; clears every entry
//   we        write enable
//   wa, wd    write address and data
//   ra1, ra2  read addresses
//   rd1, rd2  read data
module reg_bank
    import datapath_pkg::*;
#(
    parameter int DATA_W = datapath_pkg::DATA_W,
    parameter int ADDR_W = datapath_pkg::ADDR_W,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DATA_W-1:0] stored1;
    logic [DATA_W-1:0] stored2;

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    assign stored1 = regs[ra1];
    assign stored2 = regs[ra2];

    reg_bank_rport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_rport1 (
        .ra     (ra1),
        .stored (stored1),
        .we     (we),
        .rst    (rst),
        .wa     (wa),
        .wd     (wd),
        .rd     (rd1)
    );

    reg_bank_rport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_rport2 (
        .ra     (ra2),
        .stored (stored2),
        .we     (we),
        .rst    (rst),
        .wa     (wa),
        .wd     (wd),
        .rd     (rd2)
    );

endmodule
